// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: log2(WIDTH)-stage pipelined ROR/ROL/SRL/SRA shifter with valid/ready.
// Optional: define BARREL_SHIFTER_PIPE_CARRY_EN to add out_carry and the per-stage carry registers.
module barrel_shifter_pipe #(
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    output logic             out_carry,
`endif
    output logic [WIDTH-1:0] out_data
);
    localparam int L = AW;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic             w_adv;
    logic [WIDTH-1:0] r_data [L];
    logic             r_vld  [L];
    logic [AW-1:0]    r_amt  [L-1];
    logic [1:0]       r_op   [L-1];
    logic             r_sign [L-1];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    logic             r_cy   [L];
`endif

    // The whole pipe moves in lockstep; bubbles are never squeezed out.
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[L-1];
    assign out_data  = r_data[L-1];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    assign out_carry = r_cy[L-1];
`endif

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int SH = 1 << k;

        logic [WIDTH-1:0] w_d;
        logic [WIDTH-1:0] w_sh;
        logic [AW-1:0]    w_a;
        logic [1:0]       w_op;
        logic             w_s;
        logic             w_v;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        logic             w_c;
        logic             w_cn;
`endif

        if (k == 0) begin : g_src
            assign w_d  = in_data;
            assign w_a  = in_amt;
            assign w_op = in_op;
            assign w_s  = in_data[WIDTH-1];
            assign w_v  = in_valid;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            assign w_c  = 1'b0;
`endif
        end else begin : g_src
            assign w_d  = r_data[k-1];
            assign w_a  = r_amt[k-1];
            assign w_op = r_op[k-1];
            assign w_s  = r_sign[k-1];
            assign w_v  = r_vld[k-1];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            assign w_c  = r_cy[k-1];
`endif
        end

        // Remaining amount is kept right-aligned: bit 0 always steers this stage.
        always_comb begin
            w_sh = w_d;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            w_cn = w_c;
`endif
            if (w_a[0]) begin
                unique case (w_op)
                    OP_ROR: w_sh = {w_d[SH-1:0], w_d[WIDTH-1:SH]};
                    OP_ROL: w_sh = {w_d[WIDTH-SH-1:0], w_d[WIDTH-1:WIDTH-SH]};
                    OP_SRL: w_sh = {{SH{1'b0}}, w_d[WIDTH-1:SH]};
                    OP_SRA: w_sh = {{SH{w_s}}, w_d[WIDTH-1:SH]};
                endcase
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
                w_cn = (w_op == OP_ROL) ? w_d[WIDTH-SH] : w_d[SH-1];
`endif
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_vld[k]  <= 1'b0;
                r_data[k] <= '0;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
                r_cy[k]   <= 1'b0;
`endif
            end else if (w_adv) begin
                r_vld[k]  <= w_v;
                r_data[k] <= w_sh;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
                r_cy[k]   <= w_cn;
`endif
            end
        end

        if (k < L - 1) begin : g_fwd
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_amt[k]  <= '0;
                    r_op[k]   <= '0;
                    r_sign[k] <= 1'b0;
                end else if (w_adv) begin
                    r_amt[k]  <= {1'b0, w_a[AW-1:1]};
                    r_op[k]   <= w_op;
                    r_sign[k] <= w_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed and random checks of barrel_shifter_pipe
// at WIDTH 8, 32 and 64 against a bit-level reference model.
module tb_barrel_shifter_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] din;
    logic [5:0]  amt;
    logic [1:0]  op;
    int          cur;

    always #5 clk = ~clk;

    logic        iv8, iv32, iv64;
    logic        ir8, ir32, ir64;
    logic        ov8, ov32, ov64;
    logic [7:0]  od8;
    logic [31:0] od32;
    logic [63:0] od64;
    logic        ir, ov;
    logic [63:0] od;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    logic        oc8, oc32, oc64, oc;
`endif

    assign iv8  = in_valid && (cur == 0);
    assign iv32 = in_valid && (cur == 1);
    assign iv64 = in_valid && (cur == 2);

    barrel_shifter_pipe #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv8), .in_ready(ir8),
        .in_data(din[7:0]), .in_amt(amt[2:0]), .in_op(op),
        .out_valid(ov8), .out_ready(out_ready),
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        .out_carry(oc8),
`endif
        .out_data(od8)
    );

    barrel_shifter_pipe #(.WIDTH(32)) u_w32 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv32), .in_ready(ir32),
        .in_data(din[31:0]), .in_amt(amt[4:0]), .in_op(op),
        .out_valid(ov32), .out_ready(out_ready),
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        .out_carry(oc32),
`endif
        .out_data(od32)
    );

    barrel_shifter_pipe #(.WIDTH(64)) u_w64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv64), .in_ready(ir64),
        .in_data(din), .in_amt(amt), .in_op(op),
        .out_valid(ov64), .out_ready(out_ready),
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        .out_carry(oc64),
`endif
        .out_data(od64)
    );

    always_comb begin
        ir = ir32;
        ov = ov32;
        od = {32'b0, od32};
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        oc = oc32;
`endif
        if (cur == 0) begin
            ir = ir8;
            ov = ov8;
            od = {56'b0, od8};
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            oc = oc8;
`endif
        end else if (cur == 2) begin
            ir = ir64;
            ov = ov64;
            od = od64;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            oc = oc64;
`endif
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = -1;
    int          ov_cyc = -1;
    bit          stall_prev = 1'b0;
    logic [63:0] prev_od = '0;
    logic [63:0] qd[$];
    logic        qc[$];

    function automatic int wd();
        return (cur == 0) ? 8 : (cur == 1) ? 32 : 64;
    endfunction

    function automatic int lat();
        return (cur == 0) ? 3 : (cur == 1) ? 5 : 6;
    endfunction

    function automatic logic [63:0] mask();
        return (cur == 2) ? '1 : ((64'd1 << wd()) - 64'd1);
    endfunction

    // Bit-level reference: result bit i taken straight from its source position.
    function automatic logic [64:0] model(int w, logic [63:0] d, int a, logic [1:0] o);
        logic [63:0] r;
        logic        c;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (o)
                2'b00: r[i] = d[(i + a) % w];
                2'b01: r[i] = d[(i - a + w) % w];
                2'b10: r[i] = (i + a < w) ? d[i + a] : 1'b0;
                default: r[i] = (i + a < w) ? d[i + a] : d[w-1];
            endcase
        end
        if (a == 0)
            c = 1'b0;
        else if (o[1])
            c = d[a-1];
        else if (o == 2'b00)
            c = r[w-1];
        else
            c = r[0];
        return {c, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [63:0] d, input int a,
                        input logic [1:0] o, input bit ordy,
                        input bit hand = 1'b0, input logic [63:0] hd = '0,
                        input bit hc = 1'b0);
        logic [63:0] e;
        logic        ec;
        logic [64:0] m;
        bit          acc;
        in_valid  = v;
        din       = d;
        amt       = a[5:0];
        op        = o;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", {63'b0, ir}, {63'b0, ~ov | ordy});
        if (stall_prev) begin
            chk("stall_valid", {63'b0, ov}, 64'd1);
            chk("stall_data", od, prev_od);
        end
        if (ov && ov_cyc < 0) ov_cyc = cyc;
        if (ov && ordy) begin
            if (qd.size() == 0) begin
                chk("spurious_valid", {63'b0, ov}, 64'd0);
            end else begin
                e  = qd.pop_front();
                ec = qc.pop_front();
                chk("out_data", od, e);
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
                chk("out_carry", {63'b0, oc}, {63'b0, ec});
`endif
            end
        end
        acc        = v && ir;
        stall_prev = ov && !ordy;
        prev_od    = od;
        @(posedge clk);
        if (acc) begin
            if (acc_cyc < 0) acc_cyc = cyc;
            if (hand) begin
                qd.push_back(hd);
                qc.push_back(hc);
            end else begin
                m = model(wd(), d & mask(), a, o);
                qd.push_back(m[63:0]);
                qc.push_back(m[64]);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(output int n);
        n = 0;
        while (qd.size() != 0 && n < 100) begin
            step(1'b0, '0, 0, 2'b00, 1'b1);
            n++;
        end
        chk("drain_empty", 64'(qd.size()), 64'd0);
    endtask

    task automatic hand32(input logic [63:0] d, input int a, input logic [1:0] o,
                          input logic [63:0] e, input bit c);
        step(1'b1, d, a, o, 1'b1, 1'b1, e, c);
    endtask

    task automatic rand_beat(input bit v, input bit ordy);
        logic [63:0] d;
        d = {$urandom, $urandom} & mask();
        step(v, d, $urandom_range(0, wd() - 1), 2'($urandom_range(0, 3)), ordy);
    endtask

    initial begin
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din       = '0;
        amt       = '0;
        op        = 2'b00;
        cur       = 1;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", {63'b0, ov}, 64'd0);
        chk("reset_out_data", od, 64'd0);
        chk("reset_in_ready", {63'b0, ir}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Three beats in flight, then an asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++)
            step(1'b1, 64'h1234_5678 + 64'(i), i + 1, 2'(i), 1'b1);
        step(1'b0, '0, 0, 2'b00, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", {63'b0, ov}, 64'd0);
        chk("midreset_out_data", od, 64'd0);
        chk("midreset_in_ready", {63'b0, ir}, 64'd1);
        qd.delete();
        qc.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) step(1'b0, '0, 0, 2'b00, 1'b1);

        // Directed modes and boundaries at WIDTH=32.
        hand32(64'h8000_0001, 4, 2'b00, 64'h1800_0000, 1'b0);
        hand32(64'h8000_0001, 4, 2'b01, 64'h0000_0018, 1'b0);
        hand32(64'h8000_0001, 4, 2'b10, 64'h0800_0000, 1'b0);
        hand32(64'h8000_0001, 4, 2'b11, 64'hF800_0000, 1'b0);
        hand32(64'hDEAD_BEEF, 0, 2'b00, 64'hDEAD_BEEF, 1'b0);
        hand32(64'hDEAD_BEEF, 0, 2'b01, 64'hDEAD_BEEF, 1'b0);
        hand32(64'hDEAD_BEEF, 0, 2'b10, 64'hDEAD_BEEF, 1'b0);
        hand32(64'hDEAD_BEEF, 0, 2'b11, 64'hDEAD_BEEF, 1'b0);
        hand32(64'h8000_0000, 31, 2'b11, 64'hFFFF_FFFF, 1'b0);
        hand32(64'h8000_0000, 31, 2'b10, 64'h0000_0001, 1'b0);
        hand32(64'h0000_0003, 1, 2'b10, 64'h0000_0001, 1'b1);
        hand32(64'h0000_0001, 31, 2'b01, 64'h8000_0000, 1'b0);
        drain(n);

        for (int w = 0; w < 3; w++) begin
            cur = w;
            repeat (2) step(1'b0, '0, 0, 2'b00, 1'b1);

            for (int o = 0; o < 4; o++)
                step(1'b1, 64'h8000_0000_8000_0001 & mask(), 4, 2'(o), 1'b1);
            step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF & mask(), 0, 2'b11, 1'b1);
            step(1'b1, 64'h8000_0000_0000_0000 >> (64 - wd()), wd() - 1, 2'b11, 1'b1);
            step(1'b1, 64'h0000_0000_0000_0003, 1, 2'b10, 1'b1);
            drain(n);

            // Back-to-back: fixed latency and one result per clock.
            acc_cyc = -1;
            ov_cyc  = -1;
            repeat (100) rand_beat(1'b1, 1'b1);
            drain(n);
            chk("latency", 64'(ov_cyc - acc_cyc), 64'(lat()));
            chk("full_rate_drain", 64'(n), 64'(lat()));

            // Random valid and backpressure at about 50 percent.
            repeat (200) rand_beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain(n);
            repeat (lat() + 2) step(1'b0, '0, 0, 2'b00, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
